// File: rtl/bitmap_tx_sequencer.sv
// bitmap_tx_sequencer: stages up to DEPTH ciphertext words from a host, then on
// `go` streams them to the top_new bitmap load port, waits a settle gap, pulses
// start with the word count and measures cycles until the done edge.
// Optional feature: define BITMAP_TX_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (TIMEOUT_CYCLES) and the sticky error_timeout flag.
module bitmap_tx_sequencer #(
    parameter int DATA_WIDTH     = 128,
    parameter int SIZE_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  go,
    output logic [DATA_WIDTH-1:0] out_bitmap,
    output logic                  out_bitmap_valid,
    output logic [SIZE_WIDTH-1:0] out_bitmap_size,
    output logic                  out_start,
    input  logic                  in_done,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE_WIDTH-1:0] cycle_count,
    output logic                  error_timeout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  done_prev;

    logic                  wr_fire;
    logic                  go_fire;
    logic                  pop;
    logic                  done_rise;
    logic                  timeout_hit;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [SIZE_WIDTH-1:0] sat_inc(input logic [SIZE_WIDTH-1:0] v);
        return (&v) ? v : v + SIZE_WIDTH'(1);
    endfunction

    assign wr_ready  = (state == S_IDLE) && (count < CNT_W'(DEPTH)) && !go;
    assign wr_fire   = wr_valid && wr_ready;
    assign go_fire   = (state == S_IDLE) && go && (count != '0);
    assign pop       = (state == S_STREAM);
    assign done_rise = in_done && !done_prev;
    assign busy      = (state != S_IDLE);

`ifdef BITMAP_TX_TIMEOUT_EN
    assign timeout_hit = (state == S_WAIT_DONE) && !done_rise &&
                         (cycle_count == SIZE_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; STREAM ends when the final buffered word is popped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (go_fire) state_nxt = S_STREAM;
            S_STREAM:    if (count == CNT_W'(1)) state_nxt = S_GAP;
            S_GAP:       if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (done_rise || timeout_hit) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // FIFO pointers and occupancy; writes only happen in IDLE, pops only in STREAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_fire)  count <= count + CNT_W'(1);
            else if (pop) count <= count - CNT_W'(1);
        end
    end

    // Staging storage, no reset needed since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    // Settle-gap counter, runs only while in GAP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)            gap_cnt <= '0;
        else if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
        else                     gap_cnt <= '0;
    end

    // Previous in_done sample, tracked in every state so stale highs never look like edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) done_prev <= 1'b0;
        else          done_prev <= in_done;
    end

    // Registered bus, handshake and measurement outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_bitmap       <= '0;
            out_bitmap_valid <= 1'b0;
            out_bitmap_size  <= '0;
            out_start        <= 1'b0;
            done             <= 1'b0;
            cycle_count      <= '0;
        end else begin
            out_bitmap_valid <= pop;
            out_start        <= (state == S_START);
            done             <= (state == S_WAIT_DONE) && (done_rise || timeout_hit);
            if (pop) out_bitmap <= mem[rd_ptr];
            if (go_fire) begin
                out_bitmap_size <= SIZE_WIDTH'(count);
                cycle_count     <= '0;
            end else if (state == S_START) begin
                cycle_count <= '0;
            end else if ((state == S_WAIT_DONE) && !done_rise) begin
                cycle_count <= sat_inc(cycle_count);
            end
        end
    end

`ifdef BITMAP_TX_TIMEOUT_EN
    // Sticky watchdog flag, cleared only by the next accepted go.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         error_timeout <= 1'b0;
        else if (go_fire)     error_timeout <= 1'b0;
        else if (timeout_hit) error_timeout <= 1'b1;
    end
`else
    assign error_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bitmap_tx_sequencer.sv
// Testbench for bitmap_tx_sequencer: directed loads checked against a
// schedule-based model every cycle, plus literal expectations.
module tb_bitmap_tx_sequencer;

    localparam int DW    = 128;
    localparam int SW    = 32;
    localparam int DEPTH = 16;
    localparam int GAP   = 10;

    localparam logic [DW-1:0] W0 = 128'h2824d792_1a3b5c7e_90f1e2d3_c4b5f5df;
    localparam logic [DW-1:0] W1 = 128'he4762440_5566aabb_ccdd0011_22337f2a;
    localparam logic [DW-1:0] W2 = 128'h7b037343_0badf00d_deadbeef_1234bbce;
    localparam logic [DW-1:0] W3 = 128'hbbe8a4fa_13579bdf_2468ace0_fedcab19;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          go;
    logic [DW-1:0] out_bitmap;
    logic          out_bitmap_valid;
    logic [SW-1:0] out_bitmap_size;
    logic          out_start;
    logic          in_done;
    logic          busy;
    logic          done;
    logic [SW-1:0] cycle_count;
    logic          error_timeout;

    bitmap_tx_sequencer #(
        .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .DEPTH(DEPTH),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(100000)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .go(go),
        .out_bitmap(out_bitmap), .out_bitmap_valid(out_bitmap_valid),
        .out_bitmap_size(out_bitmap_size), .out_start(out_start),
        .in_done(in_done), .busy(busy), .done(done),
        .cycle_count(cycle_count), .error_timeout(error_timeout)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Observed-event counters maintained by the compare process.
    int          valid_seen = 0;
    int          start_seen = 0;
    int          done_seen  = 0;
    logic [DW-1:0] first_word = '0;

    // Model: a transfer is described by its go edge, length and start edge.
    logic [DW-1:0] staged[$];
    logic [DW-1:0] tx[$];
    int            m_edge  = 0;
    bit            active  = 0;
    int            t_go    = 0;
    int            n_words = 0;
    int            t_start = 0;
    bit            prev_in = 0;
    logic [DW-1:0] e_bitmap = '0;
    bit            e_valid = 0, e_start = 0, e_done = 0, e_busy = 0;
    logic [SW-1:0] e_size = '0, e_cc = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        staged.delete();
        tx.delete();
        active = 0; prev_in = 0; m_edge = 0;
        e_bitmap = '0; e_valid = 0; e_start = 0; e_done = 0; e_busy = 0;
        e_size = '0; e_cc = '0;
    endtask

    // Predict the outputs after the upcoming rising edge from the present inputs.
    task automatic model_advance();
        int ne;
        ne = m_edge + 1;
        e_done = 0;
        if (active) begin
            e_valid = (ne >= t_go + 1) && (ne <= t_go + n_words);
            if (e_valid) e_bitmap = tx[ne - t_go - 1];
            e_start = (ne == t_start);
            if (ne > t_start) begin
                if (in_done && !prev_in) begin
                    active = 0;
                    e_done = 1;
                end else begin
                    e_cc = SW'(ne - t_start);
                end
            end
        end else begin
            e_valid = 0;
            e_start = 0;
            if (go && staged.size() > 0) begin
                active  = 1;
                t_go    = ne;
                n_words = staged.size();
                t_start = ne + n_words + GAP + 1;
                tx      = staged;
                staged.delete();
                e_size  = SW'(n_words);
                e_cc    = '0;
            end else if (wr_valid && !go && staged.size() < DEPTH) begin
                staged.push_back(wr_data);
            end
        end
        e_busy  = active;
        prev_in = in_done;
        m_edge  = ne;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        wr_data  = w;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        while (!out_start && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!out_start) check("start_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 200) begin
            tick();
            c++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        reset_n  = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        go       = 1'b0;
        in_done  = 1'b0;

        fork
            forever begin
                @(negedge clock);
                if (!reset_n) model_reset();
                check("valid",         DW'(out_bitmap_valid), DW'(e_valid));
                check("bitmap",        out_bitmap,            e_bitmap);
                check("size",          DW'(out_bitmap_size),  DW'(e_size));
                check("start",         DW'(out_start),        DW'(e_start));
                check("busy",          DW'(busy),             DW'(e_busy));
                check("done",          DW'(done),             DW'(e_done));
                check("cycle_count",   DW'(cycle_count),      DW'(e_cc));
                check("error_timeout", DW'(error_timeout),    '0);
                check("wr_ready",      DW'(wr_ready),
                      DW'(!active && staged.size() < DEPTH && !go));
                if (out_bitmap_valid) begin
                    if (valid_seen == 0) first_word = out_bitmap;
                    valid_seen++;
                end
                if (out_start) start_seen++;
                if (done) done_seen++;
                if (reset_n) model_advance();
            end
        join_none

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check("reset_valid", DW'(out_bitmap_valid), '0);
        check("reset_size",  DW'(out_bitmap_size),  '0);
        check("reset_busy",  DW'(busy),             '0);
        check("ready_after_reset", DW'(wr_ready),   DW'(1));

        // Four-word load, done edge 37 cycles after start.
        write_word(W0); write_word(W1); write_word(W2); write_word(W3);
        valid_seen = 0; start_seen = 0; done_seen = 0;
        pulse_go();
        wait_start(cyc);
        check("go_to_start_cycles", DW'(cyc), DW'(15));
        check("load4_valid_count",  DW'(valid_seen), DW'(4));
        check("load4_first_word",   first_word, W0);
        check("load4_size",         DW'(out_bitmap_size), DW'(4));
        repeat (37) tick();
        in_done = 1'b1;
        wait_done();
        check("load4_cycle_count",  DW'(cycle_count), DW'(37));
        check("load4_busy_at_done", DW'(busy), '0);
        tick();
        check("load4_done_once",    DW'(done_seen), DW'(1));
        check("load4_start_once",   DW'(start_seen), DW'(1));
        in_done = 1'b0;
        repeat (2) tick();

        // Overfill: 17th write must be refused.
        for (int i = 0; i < 17; i++) begin
            wr_data  = {4{32'(i * 3 + 1)}};
            wr_valid = 1'b1;
            #1;
            check("fill_ready", DW'(wr_ready), DW'(i < 16));
            tick();
        end
        wr_valid = 1'b0;
        valid_seen = 0;
        pulse_go();
        wait_start(cyc);
        check("full_size",        DW'(out_bitmap_size), DW'(16));
        check("full_valid_count", DW'(valid_seen), DW'(16));
        repeat (5) tick();
        in_done = 1'b1;
        wait_done();
        check("full_cycle_count", DW'(cycle_count), DW'(5));
        tick();
        in_done = 1'b0;
        repeat (2) tick();

        // go with empty buffer, then go together with a write.
        valid_seen = 0; start_seen = 0;
        pulse_go();
        repeat (3) tick();
        check("empty_go_busy", DW'(busy), '0);
        go = 1'b1; wr_valid = 1'b1; wr_data = W0;
        #1 check("go_blocks_write", DW'(wr_ready), '0);
        tick();
        go = 1'b0; wr_valid = 1'b0;
        tick();
        pulse_go();
        repeat (3) tick();
        check("dropped_write_busy",  DW'(busy), '0);
        check("empty_go_no_valid",   DW'(valid_seen), '0);
        check("empty_go_no_start",   DW'(start_seen), '0);

        // Reset in the middle of STREAM.
        write_word(W0); write_word(W1); write_word(W2); write_word(W3);
        pulse_go();
        tick(); tick();
        check("mid_stream_word2", out_bitmap, W1);
        reset_n = 1'b0;
        done_seen = 0;
        #1;
        check("abort_valid",  DW'(out_bitmap_valid), '0);
        check("abort_bitmap", out_bitmap, '0);
        check("abort_busy",   DW'(busy), '0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", DW'(done_seen), '0);
        check("abort_idle",    DW'(busy), '0);

        // Fresh load after the abort: only the new words are sent.
        valid_seen = 0;
        write_word(W2); write_word(W3);
        pulse_go();
        wait_start(cyc);
        check("reload_size",        DW'(out_bitmap_size), DW'(2));
        check("reload_valid_count", DW'(valid_seen), DW'(2));
        check("reload_first_word",  first_word, W2);
        repeat (2) tick();
        in_done = 1'b1;
        wait_done();
        check("reload_cycle_count", DW'(cycle_count), DW'(2));
        tick();
        in_done = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
